// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padding word, loader state encoding, block-count helper and round constants.
package sha256_pkg;

    localparam logic [31:0] PAD_WORD = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        DONE
    } loader_state_e;

    // Message words plus the 0x80000000 word and the 64-bit length, rounded up to whole blocks.
    function automatic int num_blocks(int n);
        return (n + 3 + 15) / 16;
    endfunction

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_block_loader_pad_word_gen.sv
// Combinational padded-stream word for global word index g: message data, pad word, zero or bit length.
// Zero latency, no flow control.
module sha256_pad_word_gen
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic [31:0] g_i,
    input  logic [31:0] mem_read_data_i,
    output logic [31:0] word_o
);

    localparam logic [31:0] N       = 32'(NUM_OF_WORDS);
    localparam logic [31:0] L       = 32'(num_blocks(NUM_OF_WORDS) * 16);
    localparam logic [31:0] BIT_LEN = 32'(NUM_OF_WORDS * 32);

    // The upper length word (L-2) is always zero because N*32 fits in 32 bits.
    always_comb begin
        word_o = '0;
        if (g_i < N) begin
            word_o = mem_read_data_i;
        end else if (g_i == N) begin
            word_o = PAD_WORD;
        end else if (g_i == L - 32'd1) begin
            word_o = BIT_LEN;
        end
    end

endmodule

// File: rtl/sha256_block_loader.sv
// Reads an N-word message, pads it and presents 16-word blocks; 17 fill cycles per block, then holds
// the block with blk_valid until blk_ready (no combinational ready-to-output path).
module sha256_block_loader
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [31:0]       mem_read_data,
    output logic [31:0]       blk_w [16],
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              blk_first,
    output logic              blk_last,
    output logic [7:0]        blk_index,
    output logic              busy,
    output logic              done
);

    localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);
    localparam logic [31:0] N          = 32'(NUM_OF_WORDS);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] base_q, mem_addr_q;
    logic              mem_read_q, blk_valid_q, blk_first_q, blk_last_q, busy_q, done_q;
    logic [7:0]        blk_q, blk_index_q;
    logic [4:0]        k_q;
    logic [31:0]       blk_w_q [16];

    logic [31:0] blk_base_d, g_load_d, g_fetch_d, g_next_blk_d, pad_word_d;
    logic [3:0]  load_idx_d;
    logic        fetch_d, next_blk_fetch_d;

    // Cycle k loads word k-1 (data fetched in cycle k-1) and issues the fetch for cycle k+1.
    always_comb begin
        blk_base_d       = {16'd0, 4'd0, blk_q, 4'd0};
        g_load_d         = blk_base_d + {27'd0, k_q} - 32'd1;
        g_fetch_d        = blk_base_d + {27'd0, k_q} + 32'd1;
        g_next_blk_d     = blk_base_d + 32'd16;
        load_idx_d       = 4'(k_q - 5'd1);
        fetch_d          = (k_q < 5'd15) && (g_fetch_d < N);
        next_blk_fetch_d = g_next_blk_d < N;
    end

    sha256_pad_word_gen #(
        .NUM_OF_WORDS(NUM_OF_WORDS)
    ) u_pad (
        .g_i            (g_load_d),
        .mem_read_data_i(mem_read_data),
        .word_o         (pad_word_d)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            blk_q       <= '0;
            k_q         <= '0;
            for (int i = 0; i < 16; i++) blk_w_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FILL;
                        busy_q     <= 1'b1;
                        base_q     <= message_addr;
                        blk_q      <= '0;
                        k_q        <= '0;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= message_addr;
                    end
                end
                FILL: begin
                    if (k_q != 5'd0) blk_w_q[load_idx_d] <= pad_word_d;
                    k_q        <= k_q + 5'd1;
                    mem_read_q <= fetch_d;
                    if (fetch_d) mem_addr_q <= base_q + ADDR_W'(g_fetch_d);
                    if (k_q == 5'd16) begin
                        state_q     <= PRESENT;
                        blk_valid_q <= 1'b1;
                        blk_first_q <= (blk_q == 8'd0);
                        blk_last_q  <= (blk_q == LAST_BLK);
                        blk_index_q <= blk_q;
                    end
                end
                PRESENT: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        if (blk_last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FILL;
                            blk_q      <= blk_q + 8'd1;
                            k_q        <= '0;
                            mem_read_q <= next_blk_fetch_d;
                            if (next_blk_fetch_d) mem_addr_q <= base_q + ADDR_W'(g_next_blk_d);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign blk_w     = blk_w_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign blk_index = blk_index_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
